ysyx_23060111_dmem_resp: RTL and testbench
==========================================

Name: ysyx_23060111_dmem_resp

Overview:
- Data-memory responder: the memory-side end of the execute stage's load/store port.
- Accepts one load/store request at a time over a valid/ready handshake and models configurable access latency.
- Performs byte-masked writes and word reads on an internal word array, then returns data or an error over a valid/ready response channel.
- Sits between the execute/LSU logic and the simulated data RAM in the NPC.

Parameters:
- DEPTH, 4096, number of 32-bit words in the array (power of two).
- BASE, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from request acceptance to resp_valid (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_ren  input  1  load request.
- req_wen  input  1  store request.
- req_addr  input  32  byte address; bits [1:0] are ignored.
- req_wdata  input  32  store data.
- req_wmask  input  4  byte enables; bit i enables byte lane i.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts response.
- resp_rdata  output  32  load data.
- resp_err  output  1  address out of range.

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous, active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Array contents are not reset.
- FSM states are IDLE, WAIT and RESP.
- req_ready=1 only in IDLE, decoded from state. resp_valid=1 only in RESP.
- IDLE:
  - On req_valid&req_ready, capture ren, wen, addr, wdata and wmask into registers.
  - Load counter with LATENCY-1.
  - If LATENCY==1, go to RESP; otherwise go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When counter==1 at a clock edge, go to RESP on that edge.
- Access edge (the edge entering RESP):
  - in_range = (addr >= BASE) && (addr < BASE+4*DEPTH). Word index = (addr-BASE)[log2(DEPTH)+1:2].
  - If in_range and ren: resp_rdata = word before any write on this edge (read-before-write); otherwise resp_rdata=0.
  - If in_range and wen: each byte lane i with wmask[i]=1 takes wdata[8i+7:8i]; other lanes are unchanged.
  - resp_err = !in_range && (ren||wen). An out-of-range access performs no write.
  - ren=wen=0 is a no-op: resp_rdata=0, resp_err=0.
- Latency: a request accepted at edge T gives resp_valid=1 in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
- RESP:
  - resp_rdata and resp_err are held stable while resp_valid=1 && resp_ready=0.
  - On resp_valid&resp_ready, go to IDLE. req_ready returns the next cycle; there is no same-cycle back-to-back acceptance.
- req_valid while busy is ignored; the requester holds the request until req_ready.
- Reset mid-operation:
  - The FSM returns to IDLE and the pending response is discarded.
  - A store whose access edge has not yet occurred is not committed.
  - A store already committed stays in the array.
- Request fields are don't-care when req_valid=0. Only the captured copies are used after acceptance, so input changes after the handshake have no effect.

Decomposition:
- Shared package ysyx_23060111_mem_pkg:
  - state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - MEM_BASE default;
  - WMASK_W=4.
- Sub-module ysyx_23060111_dmem_array:
  - DEPTH x 32 storage;
  - synchronous read-before-write port with 4 byte enables and a single enable, driven on the access edge.
- The FSM, counter, range check and response registers stay in the top module.

Test Plan:
- Reset then store/load, LATENCY=2:
  - Store addr=0x8000_0010, wdata=0xDEADBEEF, wmask=4'hF -> resp_valid exactly 2 cycles after acceptance, resp_err=0, resp_rdata=0.
  - Load at the same address -> resp_rdata=0xDEADBEEF.
- Byte-mask store:
  - Preload word 0x1122_3344 at 0x8000_0020.
  - Store wdata=0xAABB_CCDD, wmask=4'b0101.
  - Load -> 0x11BB_33DD.
- Out-of-range access:
  - Load at 0x7FFF_FFFC -> resp_err=1, rdata=0.
  - Store at BASE+4*DEPTH -> resp_err=1.
  - Re-read the last valid word -> unchanged.
- Response backpressure:
  - Hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stable, req_ready=0.
  - req_valid pulses during this window are not accepted.
  - resp_ready=1 -> IDLE next cycle, req_ready=1.
- Simultaneous ren and wen:
  - Word=0x0000_0005; request ren=wen=1, wdata=0x0000_0009, mask=4'hF -> resp_rdata=0x0000_0005.
  - Subsequent load -> 0x0000_0009.
- Reset mid-operation, LATENCY=4:
  - Assert rst 1 cycle after accepting store 0xCAFE_F00D to a word holding 0x0 -> outputs return to reset values immediately.
  - Load afterwards -> 0x0.

Source files
------------

// File: rtl/ysyx_23060111_mem_pkg.sv
// Shared definitions for the data-memory responder and its storage array.
// Holds the FSM state encoding, the default base address and the byte-enable width.
// No logic, so no latency or backpressure of its own.
package ysyx_23060111_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] MEM_BASE = 32'h8000_0000;
  localparam int          WMASK_W  = 4;

endpackage

// File: rtl/ysyx_23060111_dmem_array.sv
// DEPTH x 32 word storage with one synchronous read-before-write port.
// Latency: rdata holds the old word from the edge where en=1; writes land on that same edge.
// No backpressure: the port acts on every edge where en=1.
module ysyx_23060111_dmem_array
  import ysyx_23060111_mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               en,
  input  logic               we,
  input  logic [WMASK_W-1:0] wmask,
  input  logic [AW-1:0]      idx,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [DEPTH];

  // Read the old word and merge enabled byte lanes on the same edge.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[idx];
      if (we) begin
        for (int i = 0; i < WMASK_W; i++) begin
          if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_23060111_dmem_resp.sv
// Data-memory responder: one load/store at a time, fixed access latency, range-checked.
// Latency: resp_valid rises LATENCY cycles after the request handshake.
// Backpressure: req_ready only in IDLE; the response holds stable until resp_ready.
module ysyx_23060111_dmem_resp
  import ysyx_23060111_mem_pkg::*;
#(
  parameter int          DEPTH   = 4096,
  parameter logic [31:0] BASE    = MEM_BASE,
  parameter int          LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_ren,
  input  logic               req_wen,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [WMASK_W-1:0] req_wmask,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_rdata,
  output logic               resp_err
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(DEPTH) * 33'd4;

  state_t state, state_nx;
  logic [3:0]         cnt;
  logic               ren_q, wen_q;
  logic [31:0]        addr_q, wdata_q;
  logic [WMASK_W-1:0] wmask_q;
  logic               rd_sel;
  logic [31:0]        arr_rdata;

  logic               fire, acc, in_range;
  logic               acc_ren, acc_wen;
  logic [31:0]        acc_addr, acc_wdata;
  logic [WMASK_W-1:0] acc_wmask;
  logic [AW-1:0]      acc_idx;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign fire       = req_valid && req_ready;
  assign resp_rdata = rd_sel ? arr_rdata : 32'd0;

  // Select access fields: with LATENCY==1 the access happens on the acceptance
  // edge itself, so the live request is used before the capture registers load.
  always_comb begin
    acc_ren   = ren_q;
    acc_wen   = wen_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wmask = wmask_q;
    acc       = (state == WAIT) && (cnt == 4'd1);
    if (state == IDLE) begin
      acc_ren   = req_ren;
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
      acc       = fire && (LATENCY == 1);
    end
    in_range = ({1'b0, acc_addr} >= {1'b0, BASE}) && ({1'b0, acc_addr} < LIMIT);
    // BASE is word aligned, so the low address bits never borrow into the index.
    acc_idx  = acc_addr[AW+1:2] - BASE[AW+1:2];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fire) state_nx = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture, latency counter and response flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 4'd0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wmask_q  <= '0;
      rd_sel   <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      if (fire) begin
        ren_q   <= req_ren;
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (acc) begin
        rd_sel   <= in_range && acc_ren;
        resp_err <= !in_range && (acc_ren || acc_wen);
      end
    end
  end

  ysyx_23060111_dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (acc && in_range && (acc_ren || acc_wen)),
    .we    (acc_wen),
    .wmask (acc_wmask),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_ysyx_23060111_dmem_resp.sv
// Bench for the data-memory responder: three instances with different depth/latency.
// Directed scenarios then random traffic against a word-map reference model.
// Drives inputs on the falling edge and samples outputs on the falling edge.
module tb_ysyx_23060111_dmem_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;
  int unsigned LAT [3] = '{2, 4, 1};
  int unsigned DEP [3] = '{4096, 64, 16};

  logic        clk = 1'b0;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_ren    [3];
  logic        req_wen    [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_wmask  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int checks = 0;
  int errors = 0;
  bit [31:0] mdl [longint];

  always #5 clk = ~clk;

  ysyx_23060111_dmem_resp #(.DEPTH(4096), .BASE(BASE), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_ren(req_ren[0]), .req_wen(req_wen[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  ysyx_23060111_dmem_resp #(.DEPTH(64), .BASE(BASE), .LATENCY(4)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_ren(req_ren[1]), .req_wen(req_wen[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  ysyx_23060111_dmem_resp #(.DEPTH(16), .BASE(BASE), .LATENCY(1)) u2 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_ren(req_ren[2]), .req_wen(req_wen[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]), .resp_valid(resp_valid[2]),
    .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: word map keyed by (unit, word index); absent entries are unknown.
  task automatic model(input int u, input bit ren, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask,
                       output logic [31:0] erd, output bit eerr, output bit known);
    longint a   = longint'(addr);
    longint b   = longint'(BASE);
    bit     inr = (a >= b) && (a < b + 4 * longint'(DEP[u]));
    longint key = (longint'(u) << 32) | ((a - b) >> 2);
    bit [31:0] w;
    erd   = 32'd0;
    known = 1'b1;
    eerr  = !inr && (ren || wen);
    if (inr && ren) begin
      known = mdl.exists(key);
      if (known) erd = mdl[key];
    end
    if (inr && wen) begin
      if (mdl.exists(key)) begin
        w = mdl[key];
        for (int i = 0; i < 4; i++) if (mask[i]) w[8*i +: 8] = wdata[8*i +: 8];
        mdl[key] = w;
      end else if (mask == 4'hF) begin
        mdl[key] = wdata;
      end
    end
  endtask

  task automatic scramble(input int u);
    req_ren[u]   = 1'($urandom);
    req_wen[u]   = 1'($urandom);
    req_addr[u]  = $urandom;
    req_wdata[u] = $urandom;
    req_wmask[u] = 4'($urandom);
  endtask

  // One request/response. rst_after>0 resets the unit that many edges after acceptance.
  task automatic txn(input int u, input bit ren, input bit wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] mask, input int hold,
                     input int rst_after, output logic [31:0] got);
    logic [31:0] erd;
    bit eerr, known;
    int n;
    got = 32'd0;
    @(negedge clk);
    req_valid[u] = 1'b1;
    req_ren[u]   = ren;
    req_wen[u]   = wen;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    req_wmask[u] = mask;
    resp_ready[u] = 1'b0;
    chk($sformatf("u%0d req_ready_idle", u), 32'(req_ready[u]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0;
    scramble(u);
    if (rst_after > 0) begin
      repeat (rst_after) @(posedge clk);
      #1 rst[u] = 1'b1;
      #1;
      chk($sformatf("u%0d rst_req_ready", u), 32'(req_ready[u]), 32'd1);
      chk($sformatf("u%0d rst_resp_valid", u), 32'(resp_valid[u]), 32'd0);
      chk($sformatf("u%0d rst_rdata", u), resp_rdata[u], 32'd0);
      chk($sformatf("u%0d rst_err", u), 32'(resp_err[u]), 32'd0);
      @(negedge clk);
      rst[u] = 1'b0;
      return;
    end
    model(u, ren, wen, addr, wdata, mask, erd, eerr, known);
    n = 0;
    while (n <= 40) begin
      @(negedge clk);
      if (resp_valid[u]) break;
      n++;
    end
    chk($sformatf("u%0d latency", u), 32'(n), 32'(LAT[u] - 1));
    got = resp_rdata[u];
    chk($sformatf("u%0d err a=%h", u, addr), 32'(resp_err[u]), 32'(eerr));
    if (known) chk($sformatf("u%0d rdata a=%h", u, addr), resp_rdata[u], erd);
    for (int i = 0; i < hold; i++) begin
      req_valid[u] = 1'($urandom);
      scramble(u);
      @(negedge clk);
      chk($sformatf("u%0d hold_valid", u), 32'(resp_valid[u]), 32'd1);
      chk($sformatf("u%0d hold_rdata", u), resp_rdata[u], got);
      chk($sformatf("u%0d hold_err", u), 32'(resp_err[u]), 32'(eerr));
      chk($sformatf("u%0d hold_req_ready", u), 32'(req_ready[u]), 32'd0);
    end
    req_valid[u]  = 1'b0;
    resp_ready[u] = 1'b1;
    @(negedge clk);
    resp_ready[u] = 1'b0;
    chk($sformatf("u%0d done_valid", u), 32'(resp_valid[u]), 32'd0);
    chk($sformatf("u%0d done_req_ready", u), 32'(req_ready[u]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, a;
    int sel;
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1;
      req_valid[u] = 1'b0;
      resp_ready[u] = 1'b0;
      scramble(u);
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d reset_req_ready", u), 32'(req_ready[u]), 32'd1);
      chk($sformatf("u%0d reset_resp_valid", u), 32'(resp_valid[u]), 32'd0);
      chk($sformatf("u%0d reset_rdata", u), resp_rdata[u], 32'd0);
      chk($sformatf("u%0d reset_err", u), 32'(resp_err[u]), 32'd0);
      rst[u] = 1'b0;
    end

    // Store then load.
    txn(0, 0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, got);
    txn(0, 1, 0, 32'h8000_0010, 32'h0, 4'h0, 0, 0, got);
    chk("load_deadbeef", got, 32'hDEAD_BEEF);
    // Byte-masked store.
    txn(0, 0, 1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, got);
    txn(0, 0, 1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, 0, got);
    txn(0, 1, 0, 32'h8000_0020, 32'h0, 4'h0, 0, 0, got);
    chk("byte_mask", got, 32'h11BB_33DD);
    // Out of range, with the last valid word as the aliasing victim.
    txn(0, 0, 1, BASE + 32'h3FFC, 32'h5555_AAAA, 4'hF, 0, 0, got);
    txn(0, 0, 1, 32'h8000_0000, 32'h0BAD_0000, 4'hF, 0, 0, got);
    txn(0, 1, 0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, 0, got);
    chk("oor_load_rdata", got, 32'd0);
    txn(0, 1, 1, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF, 0, 0, got);
    txn(0, 1, 0, BASE + 32'h3FFC, 32'h0, 4'h0, 0, 0, got);
    chk("last_word_kept", got, 32'h5555_AAAA);
    txn(0, 1, 0, 32'h8000_0000, 32'h0, 4'h0, 0, 0, got);
    chk("word0_kept", got, 32'h0BAD_0000);
    // Backpressure for 5 cycles.
    txn(0, 1, 0, 32'h8000_0010, 32'h0, 4'h0, 5, 0, got);
    chk("bp_rdata", got, 32'hDEAD_BEEF);
    // Simultaneous read and write.
    txn(0, 0, 1, 32'h8000_0040, 32'h0000_0005, 4'hF, 0, 0, got);
    txn(0, 1, 1, 32'h8000_0040, 32'h0000_0009, 4'hF, 0, 0, got);
    chk("rw_old", got, 32'h0000_0005);
    txn(0, 1, 0, 32'h8000_0040, 32'h0, 4'h0, 0, 0, got);
    chk("rw_new", got, 32'h0000_0009);
    // Reset mid-operation on the LATENCY=4 unit.
    txn(1, 0, 1, 32'h8000_0008, 32'h0, 4'hF, 0, 0, got);
    txn(1, 0, 1, 32'h8000_0008, 32'hCAFE_F00D, 4'hF, 0, 1, got);
    txn(1, 1, 0, 32'h8000_0008, 32'h0, 4'h0, 0, 0, got);
    chk("rst_no_commit", got, 32'h0);

    // Random traffic on all units.
    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 50; k++) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0:       a = BASE - 32'd4;
          1:       a = BASE + 32'(4 * DEP[u]);
          2:       a = 32'($urandom);
          3, 4:    a = BASE + 32'(4 * (DEP[u] - 1 - $urandom_range(0, 3)));
          default: a = BASE + 32'(4 * $urandom_range(0, 7));
        endcase
        a = a | 32'($urandom_range(0, 3));
        txn(u, 1'($urandom), 1'($urandom), a, $urandom,
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF,
            $urandom_range(0, 3), 0, got);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
